// File: rtl/tlb_pkg.sv
// Shared definitions for the page-table walker: PTE layout, FSM encoding, default widths.
package tlb_pkg;

    // PTE bit positions
    localparam int PTE_V       = 0;
    localparam int PTE_L       = 1;
    localparam int PTE_PTR_LSB = 2;

    // Default widths
    localparam int DEF_VPN_W  = 8;
    localparam int DEF_VPN0_W = 4;
    localparam int DEF_PPN_W  = 8;
    localparam int DEF_MEM_AW = 16;
    localparam int DEF_DATA_W = 16;

    // Walker FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK1 = 2'd1,
        WALK0 = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/tlb_walker.sv
// Two-level page-table walker: answers one TLB miss at a time with a PPN or a fault.
module tlb_walker
    import tlb_pkg::*;
#(
    parameter int VPN_W  = DEF_VPN_W,
    parameter int VPN0_W = DEF_VPN0_W,
    parameter int PPN_W  = DEF_PPN_W,
    parameter int MEM_AW = DEF_MEM_AW,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MEM_AW-1:0] ptbr,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [VPN_W-1:0]  miss_vpn,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fill_valid,
    input  logic              fill_ready,
    output logic [VPN_W-1:0]  fill_vpn,
    output logic [PPN_W-1:0]  fill_ppn,
    output logic              fill_fault
);

    state_t              state, state_s;
    logic [VPN_W-1:0]    vpn_q;
    logic [MEM_AW-1:0]   ptbr_q;
    logic [MEM_AW-1:0]   base_q;
    logic [PPN_W-1:0]    ppn_q;
    logic                fault_q;

    logic                mem_req_r, mem_req_s;
    logic [MEM_AW-1:0]   mem_addr_r, mem_addr_s;
    logic                fill_valid_r;
    logic                miss_ready_r;

    // PTE field extraction from the incoming read data
    logic                pte_v_s, pte_l_s;
    logic [MEM_AW-1:0]   pte_base_s;
    logic [PPN_W-1:0]    pte_ppn_s;
    logic [MEM_AW-1:0]   vpn1_s, vpn0_s;
    logic                rd_done_s;

    assign pte_v_s    = mem_rdata[PTE_V];
    assign pte_l_s    = mem_rdata[PTE_L];
    assign pte_base_s = MEM_AW'(mem_rdata[DATA_W-1:PTE_PTR_LSB]);
    assign pte_ppn_s  = mem_rdata[PPN_W+PTE_PTR_LSB-1:PTE_PTR_LSB];
    assign vpn1_s     = MEM_AW'(vpn_q[VPN_W-1:VPN0_W]);
    assign vpn0_s     = MEM_AW'(vpn_q[VPN0_W-1:0]);
    // An ack only counts while a request is actually outstanding
    assign rd_done_s  = mem_req_r & mem_ack;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_s;
        end
    end

    // Next state and next values of the registered memory port
    always_comb begin
        state_s    = state;
        mem_req_s  = mem_req_r;
        mem_addr_s = mem_addr_r;
        case (state)
            IDLE: begin
                mem_req_s = 1'b0;
                if (miss_valid) begin
                    state_s = WALK1;
                end else begin
                    state_s = IDLE;
                end
            end
            WALK1: begin
                if (!mem_req_r) begin
                    // First cycle after accept: launch the level-1 read
                    mem_req_s  = 1'b1;
                    mem_addr_s = ptbr_q + vpn1_s;
                end else if (mem_ack) begin
                    if (!pte_v_s || pte_l_s) begin
                        // Invalid entry or superpage leaf: no level-0 read
                        mem_req_s = 1'b0;
                        state_s   = RESP;
                    end else begin
                        // Chain straight into the level-0 read
                        mem_req_s  = 1'b1;
                        mem_addr_s = pte_base_s + vpn0_s;
                        state_s    = WALK0;
                    end
                end else begin
                    state_s = WALK1;
                end
            end
            WALK0: begin
                if (mem_ack) begin
                    mem_req_s = 1'b0;
                    state_s   = RESP;
                end else begin
                    mem_addr_s = base_q + vpn0_s;
                end
            end
            RESP: begin
                mem_req_s = 1'b0;
                if (fill_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                mem_req_s = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // Registered outputs and walk context
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_r    <= 1'b0;
            mem_addr_r   <= {MEM_AW{1'b0}};
            fill_valid_r <= 1'b0;
            miss_ready_r <= 1'b1;
            vpn_q        <= {VPN_W{1'b0}};
            ptbr_q       <= {MEM_AW{1'b0}};
            base_q       <= {MEM_AW{1'b0}};
            ppn_q        <= {PPN_W{1'b0}};
            fault_q      <= 1'b0;
        end else begin
            mem_req_r    <= mem_req_s;
            mem_addr_r   <= mem_addr_s;
            fill_valid_r <= (state_s == RESP);
            miss_ready_r <= (state_s == IDLE);
            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        vpn_q   <= miss_vpn;
                        ptbr_q  <= ptbr;
                        ppn_q   <= {PPN_W{1'b0}};
                        fault_q <= 1'b0;
                    end
                end
                WALK1: begin
                    if (rd_done_s) begin
                        if (!pte_v_s || pte_l_s) begin
                            fault_q <= 1'b1;
                            ppn_q   <= {PPN_W{1'b0}};
                        end else begin
                            base_q <= pte_base_s;
                        end
                    end
                end
                WALK0: begin
                    if (rd_done_s) begin
                        if (pte_v_s && pte_l_s) begin
                            ppn_q   <= pte_ppn_s;
                            fault_q <= 1'b0;
                        end else begin
                            ppn_q   <= {PPN_W{1'b0}};
                            fault_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign miss_ready = miss_ready_r;
    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign fill_valid = fill_valid_r;
    assign fill_vpn   = vpn_q;
    assign fill_ppn   = ppn_q;
    assign fill_fault = fault_q;

endmodule
